// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - load/store sequencer between execute stage and DMEM port
// Optional REQ timeout abort is built when DMEM_TIMEOUT_EN is defined.
package dmem_access_ctrl_pkg;
    typedef enum logic [3:0] {
        FUNC_NOP, FUNC_ADD, FUNC_SUB, FUNC_AND, FUNC_OR, FUNC_XOR,
        FUNC_SLL, FUNC_SRL, FUNC_LOAD, FUNC_STORE, FUNC_BRANCH, FUNC_JUMP
    } func_t;
endpackage

module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  exec_valid_i,
    input  func_t                 func_i,
    input  logic [DATA_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  stall_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    output logic                  err_o,
    output logic                  dmem_req_o,
    output logic [DATA_WIDTH-1:0] dmem_addr_o,
    output logic                  dmem_we_o,
    output logic [DATA_WIDTH-1:0] dmem_wdata_o,
    input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
    input  logic                  dmem_ack_i
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t                state_q;
    logic                  req_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;
    logic                  accept;

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    assign accept  = (state_q == S_IDLE) && exec_valid_i &&
                     ((func_i == FUNC_LOAD) || (func_i == FUNC_STORE));
    assign stall_o = accept || (state_q == S_REQ);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            rd_valid_q <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        we_q    <= (func_i == FUNC_STORE);
                        req_q   <= 1'b1;
                        state_q <= S_REQ;
`ifdef DMEM_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end
                end
                // we_q still distinguishes LOAD from STORE until the access retires
                S_REQ: begin
                    if (dmem_ack_i) begin
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        state_q <= S_DONE;
                        if (!we_q) begin
                            rd_data_q  <= dmem_rdata_i;
                            rd_valid_q <= 1'b1;
                        end
`ifdef DMEM_TIMEOUT_EN
                    end else if (cnt_q == CNT_LAST) begin
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                        if (!we_q) begin
                            rd_data_q  <= '0;
                            rd_valid_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
`endif
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dmem_req_o   = req_q;
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;
    assign rd_data_o    = rd_data_q;
    assign rd_valid_o   = rd_valid_q;
`ifdef DMEM_TIMEOUT_EN
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - self-checking bench for dmem_access_ctrl
// Timeout scenario is exercised when DMEM_TIMEOUT_EN is defined.
module tb_dmem_access_ctrl;
    import dmem_access_ctrl_pkg::*;

    localparam int DW  = 32;
    localparam int TMO = 4;
`ifdef DMEM_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid = 1'b0;
    func_t         func = FUNC_NOP;
    logic [DW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] rdata = '0;
    logic          ack = 1'b0;

    logic          stall_o, rd_valid_o, err_o, dmem_req_o, dmem_we_o;
    logic [DW-1:0] rd_data_o, dmem_addr_o, dmem_wdata_o;

    dmem_access_ctrl #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .rst_i(rst), .exec_valid_i(valid), .func_i(func),
        .addr_i(addr), .wdata_i(wdata), .stall_o(stall_o),
        .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .err_o(err_o),
        .dmem_req_o(dmem_req_o), .dmem_addr_o(dmem_addr_o), .dmem_we_o(dmem_we_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_rdata_i(rdata), .dmem_ack_i(ack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%h expected=0x%h", name, act, exp);
        end
    endtask

    // Transaction-level model: an outstanding access, how many REQ cycles it has
    // spent, and a one-cycle finishing phase after it retires.
    bit            m_busy = 0, m_fin = 0, m_store = 0;
    int            m_nreq = 0;
    logic          m_req = 0, m_we = 0, m_rv = 0, m_err = 0;
    logic [DW-1:0] m_addr = '0, m_wdata = '0, m_rd = '0;

    function automatic bit is_mem(input func_t f);
        return (f == FUNC_LOAD) || (f == FUNC_STORE);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_fin = 0; m_nreq = 0;
            m_req = 0; m_we = 0; m_rv = 0; m_err = 0;
            m_addr = '0; m_wdata = '0; m_rd = '0;
        end else if (m_fin) begin
            m_fin = 0; m_rv = 0; m_err = 0;
        end else if (m_busy) begin
            m_nreq++;
            if (ack || (TMO_EN && m_nreq == TMO)) begin
                m_busy = 0; m_fin = 1; m_req = 0; m_we = 0;
                m_err = !ack;
                if (!m_store) begin
                    m_rd = ack ? rdata : '0;
                    m_rv = 1;
                end
            end
        end else if (valid && is_mem(func)) begin
            m_busy = 1; m_nreq = 0; m_store = (func == FUNC_STORE);
            m_req = 1; m_we = m_store; m_addr = addr; m_wdata = wdata;
        end
    end

    bit            cmp_en = 0;
    logic          prev_req = 0;
    int            n_stall, n_req, n_req_pulse, n_we, n_err;
    logic [DW-1:0] last_addr, last_wdata;
    logic [DW-1:0] rv_q[$];

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("stall", stall_o, m_busy || (!m_fin && valid && is_mem(func)));
            chk("req", dmem_req_o, m_req);
            chk("we", dmem_we_o, m_we);
            chk("addr", dmem_addr_o, m_addr);
            chk("wdata", dmem_wdata_o, m_wdata);
            chk("rd_data", rd_data_o, m_rd);
            chk("rd_valid", rd_valid_o, m_rv);
            chk("err", err_o, m_err);
            if (stall_o) n_stall++;
            if (dmem_req_o) begin
                n_req++;
                last_addr  = dmem_addr_o;
                last_wdata = dmem_wdata_o;
            end
            if (dmem_req_o && !prev_req) n_req_pulse++;
            if (dmem_req_o && dmem_we_o) n_we++;
            if (err_o) n_err++;
            if (rd_valid_o) rv_q.push_back(rd_data_o);
        end
        prev_req = dmem_req_o;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        n_stall = 0; n_req = 0; n_req_pulse = 0; n_we = 0; n_err = 0;
        last_addr = '0; last_wdata = '0;
        rv_q.delete();
    endtask

    task automatic idle();
        valid = 0; func = FUNC_NOP; ack = 0; rdata = '0;
    endtask

    // Accept cycle, n_wait REQ cycles without ack, one REQ cycle with ack, DONE.
    // Returns at the start of the cycle after DONE.
    task automatic run_mem(input func_t f, input logic [DW-1:0] a, input logic [DW-1:0] wd,
                           input logic [DW-1:0] rd, input int n_wait);
        valid = 1; func = f; addr = a; wdata = wd; ack = 0;
        step();
        for (int i = 0; i < n_wait; i++) step();
        ack = 1; rdata = rd;
        step();
        ack = 0; rdata = '0;
        step();
    endtask

    initial begin
        clr();
        step();
        step();
        rst = 0;
        cmp_en = 1;
        @(negedge clk);
        chk("reset_req", dmem_req_o, 0);
        chk("reset_we", dmem_we_o, 0);
        chk("reset_addr", dmem_addr_o, 0);
        chk("reset_rd_data", rd_data_o, 0);
        chk("reset_rd_valid", rd_valid_o, 0);
        chk("reset_err", err_o, 0);
        chk("reset_stall", stall_o, 0);
        step();

        // LOAD acked in the first REQ cycle
        clr();
        run_mem(FUNC_LOAD, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 0);
        idle();
        chk("t1_req_cycles", n_req, 1);
        chk("t1_req_addr", last_addr, 32'h40);
        chk("t1_we_cycles", n_we, 0);
        chk("t1_stall_cycles", n_stall, 2);
        chk("t1_rv_count", rv_q.size(), 1);
        if (rv_q.size() > 0) chk("t1_rv_data", rv_q[0], 32'hDEAD_BEEF);
        chk("t1_model_rd", m_rd, 32'hDEAD_BEEF);
        step();

        // STORE acked in the third REQ cycle
        clr();
        run_mem(FUNC_STORE, 32'h10, 32'h1234_5678, 32'hFFFF_FFFF, 2);
        idle();
        chk("t2_req_cycles", n_req, 3);
        chk("t2_we_cycles", n_we, 3);
        chk("t2_wdata", last_wdata, 32'h1234_5678);
        chk("t2_stall_cycles", n_stall, 4);
        chk("t2_rv_count", rv_q.size(), 0);
        chk("t2_rd_data_kept", rd_data_o, 32'hDEAD_BEEF);
        step();

        // non-memory op, then spurious ack in IDLE
        clr();
        valid = 1; func = FUNC_ADD; addr = 32'h55; wdata = 32'h66;
        step();
        valid = 0; ack = 1; rdata = 32'h0BAD_0BAD;
        step();
        idle();
        step();
        chk("t3_stall_cycles", n_stall, 0);
        chk("t3_req_cycles", n_req, 0);
        chk("t3_rv_count", rv_q.size(), 0);
        chk("t3_rd_data_kept", rd_data_o, 32'hDEAD_BEEF);
        chk("t3_addr_kept", dmem_addr_o, 32'h10);

        // back-to-back LOADs; second presented in the cycle after DONE
        clr();
        run_mem(FUNC_LOAD, 32'h100, 32'h0, 32'hA5A5_0001, 1);
        run_mem(FUNC_LOAD, 32'h104, 32'h0, 32'h5A5A_0002, 0);
        idle();
        chk("t4_req_pulses", n_req_pulse, 2);
        chk("t4_stall_cycles", n_stall, 5);
        chk("t4_rv_count", rv_q.size(), 2);
        if (rv_q.size() > 1) begin
            chk("t4_rv_data0", rv_q[0], 32'hA5A5_0001);
            chk("t4_rv_data1", rv_q[1], 32'h5A5A_0002);
        end
        chk("t4_last_addr", last_addr, 32'h104);
        step();

        // reset during the second REQ cycle, late ack afterwards
        clr();
        valid = 1; func = FUNC_LOAD; addr = 32'h300; ack = 0;
        step();
        step();
        rst = 1;
        step();
        rst = 0; valid = 0; func = FUNC_NOP; ack = 1; rdata = 32'hBAD0_0BAD;
        @(negedge clk);
        chk("t5_req_after_rst", dmem_req_o, 0);
        chk("t5_rd_data_after_rst", rd_data_o, 0);
        chk("t5_stall_after_rst", stall_o, 0);
        step();
        idle();
        step();
        chk("t5_req_cycles", n_req, 2);
        chk("t5_rv_count", rv_q.size(), 0);
        chk("t5_addr_reset", dmem_addr_o, 0);

`ifdef DMEM_TIMEOUT_EN
        // LOAD never acked: aborted after TMO REQ cycles
        clr();
        valid = 1; func = FUNC_LOAD; addr = 32'h200; ack = 0;
        step();
        for (int i = 0; i < TMO; i++) step();
        step();
        idle();
        chk("t6_req_cycles", n_req, 4);
        chk("t6_stall_cycles", n_stall, 5);
        chk("t6_err_pulses", n_err, 1);
        chk("t6_rv_count", rv_q.size(), 1);
        if (rv_q.size() > 0) chk("t6_rv_data", rv_q[0], 32'h0);
        step();
`endif

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
